// File: rtl/gen_1101_tx.sv
// Serial frame transmitter: 1101 marker, payload MSB-first, then GAP_BITS guard zeros.
// First marker bit on dout the cycle after load&&ready; ready stays low for the whole frame, and load is not queued.
module gen_1101_tx #(
   parameter int DATA_W   = 8,
   parameter int GAP_BITS = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] data_in,
   input  logic              load,
   output logic              ready,
   output logic              dout,
   output logic              dout_en,
   output logic              frame_done
);

   localparam int DCW = $clog2(DATA_W + 1);
   localparam int GCW = $clog2(GAP_BITS + 1);
   localparam logic [DCW-1:0] DATA_LAST = DCW'(DATA_W - 1);
   localparam logic [GCW-1:0] GAP_LAST  = GCW'(GAP_BITS - 1);
   localparam logic [3:0]     MARKER    = 4'b1101;

   typedef enum logic [1:0] {IDLE, SYNC, DATA, GAP} state_t;

   state_t            state, state_nxt;
   logic [1:0]        sync_cnt, sync_nxt;
   logic [DCW-1:0]    data_cnt, data_nxt;
   logic [GCW-1:0]    gap_cnt, gap_nxt;
   logic [DATA_W-1:0] shreg, sh_nxt;
   logic              dout_nxt, en_nxt, fd_nxt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         sync_cnt   <= '0;
         data_cnt   <= '0;
         gap_cnt    <= '0;
         shreg      <= '0;
         dout       <= 1'b0;
         dout_en    <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         state      <= state_nxt;
         sync_cnt   <= sync_nxt;
         data_cnt   <= data_nxt;
         gap_cnt    <= gap_nxt;
         shreg      <= sh_nxt;
         dout       <= dout_nxt;
         dout_en    <= en_nxt;
         frame_done <= fd_nxt;
      end
   end

   // Outputs are registered, so they are derived from the next state and next counters.
   always_comb begin
      state_nxt = state;
      sync_nxt  = sync_cnt;
      data_nxt  = data_cnt;
      gap_nxt   = gap_cnt;
      sh_nxt    = shreg;
      dout_nxt  = 1'b0;
      en_nxt    = 1'b0;
      fd_nxt    = 1'b0;

      case (state)
         IDLE: begin
            if (load) begin
               state_nxt = SYNC;
               sync_nxt  = '0;
               sh_nxt    = data_in;
            end
         end
         SYNC: begin
            if (sync_cnt == 2'd3) begin
               state_nxt = DATA;
               data_nxt  = '0;
            end else begin
               sync_nxt = sync_cnt + 2'd1;
            end
         end
         DATA: begin
            if (data_cnt == DATA_LAST) begin
               state_nxt = GAP;
               gap_nxt   = '0;
            end else begin
               data_nxt = data_cnt + 1'b1;
               sh_nxt   = shreg << 1;
            end
         end
         GAP: begin
            if (gap_cnt == GAP_LAST) begin
               state_nxt = IDLE;
            end else begin
               gap_nxt = gap_cnt + 1'b1;
            end
         end
         default: begin
            state_nxt = IDLE;
            sync_nxt  = '0;
            data_nxt  = '0;
            gap_nxt   = '0;
            sh_nxt    = '0;
         end
      endcase

      case (state_nxt)
         SYNC: begin
            dout_nxt = MARKER[2'd3 - sync_nxt];
            en_nxt   = 1'b1;
         end
         DATA: begin
            dout_nxt = sh_nxt[DATA_W-1];
            en_nxt   = 1'b1;
            fd_nxt   = (data_nxt == DATA_LAST);
         end
         default: begin
            dout_nxt = 1'b0;
            en_nxt   = 1'b0;
            fd_nxt   = 1'b0;
         end
      endcase
   end

   assign ready = (state == IDLE);

endmodule

// File: tb/tb_gen_1101_tx.sv
// Bench for gen_1101_tx: per-cycle queue model of the frame stream plus literal frame expectations.
module tb_gen_1101_tx;
   localparam int W = 8;
   localparam int G = 2;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] data_in;
   logic       load, ready, dout, dout_en, frame_done;
   logic [0:0] data1;
   logic       load1, ready1, dout1, en1, fd1;

   always #5 clk = ~clk;

   gen_1101_tx #(.DATA_W(W), .GAP_BITS(G)) dut (
      .clk(clk), .rst_n(rst_n), .data_in(data_in), .load(load),
      .ready(ready), .dout(dout), .dout_en(dout_en), .frame_done(frame_done));

   gen_1101_tx #(.DATA_W(1), .GAP_BITS(3)) dut1 (
      .clk(clk), .rst_n(rst_n), .data_in(data1), .load(load1),
      .ready(ready1), .dout(dout1), .dout_en(en1), .frame_done(fd1));

   int n_chk  = 0;
   int n_pass = 0;
   bit chk_on = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // Reference model: each accepted frame becomes a list of expected per-cycle outputs.
   typedef struct packed {logic d; logic en; logic fd;} cyc_t;
   cyc_t       q[$];
   logic       m_dout = 1'b0, m_en = 1'b0, m_fd = 1'b0, m_rdy = 1'b1;
   logic [3:0] mk = 4'b1101;

   task automatic model_reset();
      q.delete();
      m_dout = 1'b0; m_en = 1'b0; m_fd = 1'b0; m_rdy = 1'b1;
   endtask

   task automatic push_frame(input logic [7:0] p);
      for (int i = 3; i >= 0; i--) q.push_back('{mk[i], 1'b1, 1'b0});
      for (int i = W-1; i >= 0; i--) q.push_back('{p[i], 1'b1, (i == 0)});
      for (int i = 0; i < G; i++) q.push_back('{1'b0, 1'b0, 1'b0});
   endtask

   task automatic model_edge();
      cyc_t c;
      if (!rst_n) begin
         model_reset();
         return;
      end
      if (m_rdy && load) push_frame(data_in);
      if (q.size() > 0) begin
         c = q.pop_front();
         m_dout = c.d; m_en = c.en; m_fd = c.fd; m_rdy = 1'b0;
      end else begin
         m_dout = 1'b0; m_en = 1'b0; m_fd = 1'b0; m_rdy = 1'b1;
      end
   endtask

   always @(negedge clk) begin
      if (chk_on) begin
         chk("dout", 32'(dout), 32'(m_dout));
         chk("dout_en", 32'(dout_en), 32'(m_en));
         chk("frame_done", 32'(frame_done), 32'(m_fd));
         chk("ready", 32'(ready), 32'(m_rdy));
      end
   end

   task automatic tick();
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   task automatic reset_pulse();
      #2 rst_n = 1'b0;
      model_reset();
      #1;
      chk("rst_async_dout", 32'(dout), 32'd0);
      chk("rst_async_en", 32'(dout_en), 32'd0);
      chk("rst_async_fd", 32'(frame_done), 32'd0);
      chk("rst_async_rdy", 32'(ready), 32'd1);
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   // Non-overlapping 1101 detector on the looped-back stream.
   logic [3:0] dh;
   int dn, det;
   task automatic det_feed(input logic b);
      dh = {dh[2:0], b};
      dn++;
      if (dn >= 4 && dh == 4'b1101) begin
         det++;
         dn = 0;
      end
   endtask

   logic [13:0] r_d, r_e, r_f, r_r;
   logic [7:0]  s_d, s_e, s_f, s_r;
   int rdy_idx, en_idx, en_cnt;

   initial begin
      rst_n = 1'b0; load = 1'b0; data_in = 8'h00; load1 = 1'b0; data1 = 1'b0;
      model_reset();
      #1;
      chk("reset_dout", 32'(dout), 32'd0);
      chk("reset_rdy", 32'(ready), 32'd1);
      tick(); tick();
      rst_n = 1'b1;
      chk_on = 1'b1;
      for (int c = 0; c < 5; c++) tick();
      chk("idle_rdy", 32'(ready), 32'd1);
      chk("idle_en", 32'(dout_en), 32'd0);

      // single frame A5
      data_in = 8'hA5; load = 1'b1;
      tick();
      load = 1'b0; data_in = 8'($urandom);
      for (int i = 0; i < 14; i++) begin
         r_d[13-i] = dout; r_e[13-i] = dout_en; r_f[13-i] = frame_done; r_r[13-i] = ready;
         tick();
      end
      chk("a5_dout", 32'(r_d), 32'(14'b11011010010100));
      chk("a5_en", 32'(r_e), 32'(14'b11111111111100));
      chk("a5_fd", 32'(r_f), 32'(14'b00000000000100));
      chk("a5_rdy_low", 32'(r_r), 32'd0);
      chk("a5_rdy_back", 32'(ready), 32'd1);

      // back-to-back FF then 00 with load held
      dh = 4'b0; dn = 0; det = 0; rdy_idx = -1; en_idx = -1;
      data_in = 8'hFF; load = 1'b1;
      det_feed(dout);
      tick();
      data_in = 8'h00;
      for (int c = 1; c <= 40; c++) begin
         det_feed(dout);
         if (rdy_idx < 0 && ready) rdy_idx = c;
         else if (rdy_idx >= 0 && en_idx < 0 && dout_en) en_idx = c;
         if (rdy_idx >= 0 && c == rdy_idx + 1) load = 1'b0;
         tick();
      end
      chk("b2b_rdy_idx", 32'(rdy_idx), 32'd15);
      chk("b2b_marker_idx", 32'(en_idx), 32'd16);
      chk("b2b_detections", 32'(det), 32'd2);

      // load during DATA must be ignored
      data_in = 8'h96; load = 1'b1;
      tick();
      load = 1'b0; en_cnt = 0;
      for (int c = 1; c <= 6; c++) begin en_cnt += int'(dout_en); tick(); end
      data_in = 8'h3C; load = 1'b1;
      en_cnt += int'(dout_en);
      tick();
      load = 1'b0;
      for (int c = 8; c <= 40; c++) begin en_cnt += int'(dout_en); tick(); end
      chk("ignore_load_en_cycles", 32'(en_cnt), 32'd12);

      // reset at payload bit 3 of C3
      data_in = 8'hC3; load = 1'b1;
      tick();
      load = 1'b0;
      for (int c = 0; c < 8; c++) tick();
      chk("pre_rst_en", 32'(dout_en), 32'd1);
      load = 1'b1;
      reset_pulse();
      load = 1'b0;
      en_cnt = 0;
      for (int c = 0; c < 20; c++) begin en_cnt += int'(dout_en); tick(); end
      chk("post_rst_no_bits", 32'(en_cnt), 32'd0);
      chk("post_rst_rdy", 32'(ready), 32'd1);

      // DATA_W=1, GAP_BITS=3
      chk("w1_rdy_idle", 32'(ready1), 32'd1);
      data1 = 1'b1; load1 = 1'b1;
      tick();
      load1 = 1'b0; data1 = 1'b0;
      for (int i = 0; i < 8; i++) begin
         s_d[7-i] = dout1; s_e[7-i] = en1; s_f[7-i] = fd1; s_r[7-i] = ready1;
         tick();
      end
      chk("w1_dout", 32'(s_d), 32'(8'b11011000));
      chk("w1_en", 32'(s_e), 32'(8'b11111000));
      chk("w1_fd", 32'(s_f), 32'(8'b00001000));
      chk("w1_rdy_low", 32'(s_r), 32'd0);
      chk("w1_rdy_back", 32'(ready1), 32'd1);

      // randomized traffic with occasional mid-frame resets
      for (int c = 0; c < 400; c++) begin
         load = ($urandom_range(0, 2) == 0);
         data_in = 8'($urandom);
         if ($urandom_range(0, 149) == 0) reset_pulse();
         else tick();
      end
      load = 1'b0;
      for (int c = 0; c < 20; c++) tick();

      chk_on = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
